// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// default latencies, FSM state type and small opcode classifiers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    logic res;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

  // True for the division opcodes (selects the longer latency).
  function automatic logic is_div_op(input logic [2:0] op);
    logic res;
    case (op)
      MDU_DIV, MDU_DIVU: res = 1'b1;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Operands are captured at start; results are computed combinationally
// from the captured copies and committed to HI/LO only on the final
// busy cycle, so HI/LO always show committed values.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] a_r, a_nxt_s;
  logic [31:0] b_r, b_nxt_s;
  logic [2:0]  op_r, op_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic        busy_r, busy_nxt_s;

  // Arithmetic on the captured operands only.
  logic signed [63:0] a_sx_s, b_sx_s;
  logic signed [63:0] prod_signed_s;
  logic [63:0]        prod_unsigned_s;
  logic               div_zero_s;
  logic [31:0]        divisor_s;
  logic [31:0]        quot_signed_s, rem_signed_s;
  logic [31:0]        quot_unsigned_s, rem_unsigned_s;

  assign a_sx_s          = {{32{a_r[31]}}, a_r};
  assign b_sx_s          = {{32{b_r[31]}}, b_r};
  assign prod_signed_s   = a_sx_s * b_sx_s;
  assign prod_unsigned_s = {32'd0, a_r} * {32'd0, b_r};

  // A zero divisor is replaced by one so the dividers never see zero;
  // the result is discarded in that case anyway.
  assign div_zero_s      = (b_r == 32'd0);
  assign divisor_s       = div_zero_s ? 32'd1 : b_r;
  assign quot_signed_s   = $signed(a_r) / $signed(divisor_s);
  assign rem_signed_s    = $signed(a_r) % $signed(divisor_s);
  assign quot_unsigned_s = a_r / divisor_s;
  assign rem_unsigned_s  = a_r % divisor_s;

  // Next-state, counter, operand capture and HI/LO update logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    op_nxt_s    = op_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start && is_long_op(mdu_op)) begin
          a_nxt_s     = A;
          b_nxt_s     = B;
          op_nxt_s    = mdu_op;
          cnt_nxt_s   = is_div_op(mdu_op) ? DIV_CNT : MULT_CNT;
          state_nxt_s = ST_BUSY;
        end else if (mdu_op == MDU_MTHI) begin
          hi_nxt_s = A;
        end else if (mdu_op == MDU_MTLO) begin
          lo_nxt_s = A;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ST_IDLE;
          case (op_r)
            MDU_MULT:  {hi_nxt_s, lo_nxt_s} = prod_signed_s;
            MDU_MULTU: {hi_nxt_s, lo_nxt_s} = prod_unsigned_s;
            MDU_DIV: begin
              if (!div_zero_s) begin
                lo_nxt_s = quot_signed_s;
                hi_nxt_s = rem_signed_s;
              end else begin
                lo_nxt_s = lo_r;
                hi_nxt_s = hi_r;
              end
            end
            MDU_DIVU: begin
              if (!div_zero_s) begin
                lo_nxt_s = quot_unsigned_s;
                hi_nxt_s = rem_unsigned_s;
              end else begin
                lo_nxt_s = lo_r;
                hi_nxt_s = hi_r;
              end
            end
            default: begin
              lo_nxt_s = lo_r;
              hi_nxt_s = hi_r;
            end
          endcase
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_BUSY);
  end

  // State, counter, captured operands and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 3'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      op_r    <= op_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the multiply/divide unit.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp;
  int n_err;
  int n_busy;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: MULT start pulse during busy; 2: reset at busy cycle 3;
  // 3: MTHI during busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, output int nb);
    int  n;
    bit  done;
    @(negedge clk);
    check_val("busy_in_start_cycle", {31'd0, busy}, 32'd0);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    A      = 32'h0;
    B      = 32'h0;
    n      = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (n == 1) begin
          check_val("hi_hidden", HI, exp_hi);
          check_val("lo_hidden", LO, exp_lo);
        end
        if (mode == 1 && n == 3) begin
          start = 1'b1; mdu_op = MDU_MULT; A = 32'd2; B = 32'd3;
        end else if (mode == 3 && n == 3) begin
          mdu_op = MDU_MTHI; A = 32'h00000BAD;
        end else if (n == 4) begin
          start = 1'b0; mdu_op = MDU_NONE; A = 32'h0; B = 32'h0;
        end
        if (mode == 2 && n == 3) begin
          reset = 1'b1;
          #1;
          check_val("rst_busy", {31'd0, busy}, 32'd0);
          check_val("rst_hi", HI, 32'd0);
          check_val("rst_lo", LO, 32'd0);
          done = 1'b1;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check_val("busy_timeout", {31'd0, busy}, 32'd0);
    start  = 1'b0;
    mdu_op = MDU_NONE;
    nb = n;
  endtask

  task automatic move_op(input logic [2:0] op, input logic [31:0] a, input logic st);
    @(negedge clk);
    start  = st;
    mdu_op = op;
    A      = a;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    A      = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    A      = 32'h0;
    B      = 32'h0;
    #2;
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_hi", HI, 32'd0);
    check_val("reset_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, 0, n_busy);
    check_val("mult_cycles", n_busy, 32'd5);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFE;
    check_val("mult_hi", HI, exp_hi);
    check_val("mult_lo", LO, exp_lo);

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 0, n_busy);
    check_val("multu_cycles", n_busy, 32'd5);
    exp_hi = 32'h00000001; exp_lo = 32'hFFFFFFFE;
    check_val("multu_hi", HI, exp_hi);
    check_val("multu_lo", LO, exp_lo);

    run_op(MDU_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 0, n_busy);
    exp_hi = 32'h00000000; exp_lo = 32'h0000000F;
    check_val("mult_negneg_hi", HI, exp_hi);
    check_val("mult_negneg_lo", LO, exp_lo);

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, n_busy);
    check_val("div_cycles", n_busy, 32'd10);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
    check_val("div_hi", HI, exp_hi);
    check_val("div_lo", LO, exp_lo);

    run_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, 0, n_busy);
    exp_hi = 32'h00000001; exp_lo = 32'hFFFFFFFD;
    check_val("div_negdiv_hi", HI, exp_hi);
    check_val("div_negdiv_lo", LO, exp_lo);

    run_op(MDU_DIVU, 32'd100, 32'd7, 1, n_busy);
    check_val("divu_startbusy_cycles", n_busy, 32'd10);
    exp_hi = 32'd2; exp_lo = 32'd14;
    check_val("divu_hi", HI, exp_hi);
    check_val("divu_lo", LO, exp_lo);
    check_val("divu_idle_after", {31'd0, busy}, 32'd0);

    move_op(MDU_MTHI, 32'h00000011, 1'b0);
    exp_hi = 32'h00000011;
    check_val("mthi_hi", HI, exp_hi);
    check_val("mthi_busy", {31'd0, busy}, 32'd0);
    move_op(MDU_MTLO, 32'h00000022, 1'b0);
    exp_lo = 32'h00000022;
    check_val("mtlo_lo", LO, exp_lo);
    check_val("mtlo_hi_kept", HI, exp_hi);

    run_op(MDU_DIVU, 32'h12345678, 32'd0, 3, n_busy);
    check_val("div0_cycles", n_busy, 32'd10);
    check_val("div0_hi", HI, exp_hi);
    check_val("div0_lo", LO, exp_lo);

    move_op(MDU_MTHI, 32'h00001234, 1'b0);
    exp_hi = 32'h00001234;
    check_val("mthi2_hi", HI, exp_hi);
    check_val("mthi2_busy", {31'd0, busy}, 32'd0);
    check_val("mthi2_lo_kept", LO, exp_lo);

    move_op(MDU_MTLO, 32'h00005555, 1'b1);
    exp_lo = 32'h00005555;
    check_val("mtlo_start_lo", LO, exp_lo);
    check_val("mtlo_start_busy", {31'd0, busy}, 32'd0);

    run_op(MDU_MULT, 32'd3, 32'd4, 2, n_busy);
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_val("post_rst_hi", HI, exp_hi);
    check_val("post_rst_lo", LO, exp_lo);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, gives the busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, gives the busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage instruction is a mult/multu/div/divu this cycle.
REQ-006 mdu_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; other codes are treated as NONE.
REQ-007 A  input  32  forwarded rs operand (E stage).
REQ-008 B  input  32  forwarded rt operand (E stage).
REQ-009 busy  output  1  computation in flight; registered.
REQ-010 HI  output  32  architectural HI register; feeds the E/M register.
REQ-011 LO  output  32  architectural LO register; feeds the E/M register.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-013 In IDLE, when start=1 and mdu_op is MULT/MULTU/DIV/DIVU, the block SHALL latch A, B and mdu_op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the same edge.
REQ-014 busy SHALL be 0 during the start cycle and 1 for exactly MULT_CYCLES or DIV_CYCLES cycles after it.
REQ-015 In BUSY, cnt SHALL decrement every edge; at the edge where cnt==1, the block SHALL write HI/LO and return to IDLE, with busy=0 in the following cycle.
REQ-016 MULT SHALL set {HI,LO} to the signed 64-bit product of the latched operands.
REQ-017 MULTU SHALL set {HI,LO} to the unsigned 64-bit product of the latched operands.
REQ-018 DIV SHALL set LO to the signed quotient (truncated toward zero) and HI to the remainder (sign of the dividend).
REQ-019 DIVU SHALL set LO to the unsigned quotient and HI to the unsigned remainder.
REQ-020 DIV/DIVU with a latched divisor of 0 SHALL leave HI and LO unchanged; the busy timing SHALL be identical to a normal division.
REQ-021 The results of a division SHALL depend only on the operands latched at start, never on later A/B values.
REQ-022 MTHI in IDLE SHALL write A to HI at the next edge; MTLO in IDLE SHALL write A to LO at the next edge; neither SHALL assert busy.
REQ-023 start, MTHI and MTLO SHALL all be ignored while in BUSY; the hazard unit stalls on (start | busy) so that these events do not occur legally.
REQ-024 HI and LO SHALL expose only committed values; a product or quotient SHALL NOT become visible before completion.
REQ-025 MTHI/MTLO presented with start=1 SHALL follow REQ-022 (start applies only to mult/div opcodes).

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, cnt=0, busy=0, HI=0, LO=0 and clear the latched operands, independently of clk.
REQ-027 reset asserted mid-operation SHALL discard the pending result; no HI/LO write SHALL occur after reset is released.

Structure
REQ-028 The opcode encodings (MDU_NONE through MDU_MTLO) and the default cycle counts SHALL live in the shared package mdu_pkg, which the controller also uses.
REQ-029 The block SHALL be a single module with no sub-modules; product and quotient are computed combinationally from the latched operands and registered at completion.

Verification
REQ-030 Multiply: MULT with A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 Signed division: DIV with A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; A changed to 0 during busy -> results unchanged.
REQ-032 Divide by zero: MTHI 0x11, MTLO 0x22, then DIVU with B=0 -> busy high for 10 cycles, then HI=0x11, LO=0x22.
REQ-033 Move to HI: MTHI with A=0x00001234 in IDLE -> HI=0x00001234 after one edge, busy stays 0.
REQ-034 Reset mid-multiply: reset asserted in the third busy cycle of MULT 3x4 -> busy=0 and HI=LO=0 without waiting for a clock edge, and after release HI/LO stay 0.
REQ-035 Start while busy: start with MULT 2x3 during DIVU 100/7 -> pulse ignored, final LO=14, HI=2, busy 10 cycles total.
